// File: rtl/crc_engine.sv
// Parametrised multi-bit-per-cycle CRC engine.
// Words arrive over a valid/ready handshake; each word is folded BPC bits
// per clock into a running CRC that spans the words of a message. The final
// (optionally reflected and XORed) CRC is published with a one-cycle pulse.
module crc_engine #(
  parameter int unsigned CRC_W       = 32,
  parameter logic [31:0] POLY        = 32'h04C11DB7,
  parameter logic [31:0] INIT        = 32'hFFFFFFFF,
  parameter logic [31:0] XOR_OUT     = 32'h00000000,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned BPC         = 1,
  parameter bit          REFLECT_IN  = 1'b0,
  parameter bit          REFLECT_OUT = 1'b0
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              crc_clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              busy,
  output logic              out_valid,
  output logic [CRC_W-1:0]  crc_out
);

  localparam int unsigned N     = DATA_W / BPC;
  localparam int unsigned CNT_W = $clog2(N) + 1;
  localparam logic [CRC_W-1:0] POLY_C = POLY[CRC_W-1:0];
  localparam logic [CRC_W-1:0] INIT_C = INIT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] XOR_C  = XOR_OUT[CRC_W-1:0];

  if (CRC_W < 8 || CRC_W > 32) begin : g_bad_crc_w
    $error("crc_engine: CRC_W must be in 8..32");
  end
  if (BPC < 1 || BPC > DATA_W || (DATA_W % BPC) != 0) begin : g_bad_bpc
    $error("crc_engine: BPC must divide DATA_W and lie in 1..DATA_W");
  end

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   shreg_q;
  logic                last_q;
  logic [CRC_W-1:0]    crc_q;
  logic [CRC_W-1:0]    crc_fold;
  logic [CRC_W-1:0]    crc_final;
  logic [BPC-1:0]      chunk;
  logic                accept;
  logic                last_step;

  assign last_step = (cnt_q == CNT_W'(N - 1));

  function automatic logic [CRC_W-1:0] bitrev(input logic [CRC_W-1:0] v);
    logic [CRC_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < CRC_W; i++) r[i] = v[CRC_W-1-i];
    return r;
  endfunction

  // Fold the next BPC message bits into the CRC, one bit after another.
  always_comb begin
    logic fb;
    fb       = 1'b0;
    crc_fold = crc_q;
    chunk    = REFLECT_IN ? shreg_q[BPC-1:0] : shreg_q[DATA_W-1 -: BPC];
    for (int unsigned i = 0; i < BPC; i++) begin
      fb       = crc_fold[CRC_W-1] ^ (REFLECT_IN ? chunk[i] : chunk[BPC-1-i]);
      crc_fold = {crc_fold[CRC_W-2:0], 1'b0} ^ (fb ? POLY_C : '0);
    end
    crc_final = (REFLECT_OUT ? bitrev(crc_fold) : crc_fold) ^ XOR_C;
  end

  // Next-state and handshake outputs; crc_clear overrides everything.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    accept   = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = !crc_clear;
        accept   = in_valid && !crc_clear;
        if (accept) state_d = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_step) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (crc_clear) state_d = IDLE;
  end

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Word capture, per-cycle fold and running CRC bookkeeping.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      crc_q   <= INIT_C;
      cnt_q   <= '0;
      shreg_q <= '0;
      last_q  <= 1'b0;
    end else if (crc_clear) begin
      crc_q <= INIT_C;
      cnt_q <= '0;
    end else if (accept) begin
      shreg_q <= in_data;
      last_q  <= in_last;
      cnt_q   <= '0;
    end else if (busy) begin
      crc_q   <= (last_step && last_q) ? INIT_C : crc_fold;
      shreg_q <= REFLECT_IN ? (shreg_q >> BPC) : (shreg_q << BPC);
      cnt_q   <= last_step ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Result publication on completion of a message's final word.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      out_valid <= 1'b0;
      crc_out   <= '0;
    end else begin
      out_valid <= 1'b0;
      if (busy && last_step && last_q && !crc_clear) begin
        out_valid <= 1'b1;
        crc_out   <= crc_final;
      end
    end
  end

endmodule

// File: doc/crc_engine.md
Name: crc_engine

Overview:
- Parametrised, multi-bit-per-cycle CRC engine. Next generation of the team's bit-serial CRC32 block.
- Width, polynomial, init/xor values, reflection and data word width are all parameters.
- Accepts data words over a valid/ready handshake and folds them into a running CRC across multi-word messages.
- Sits behind the control register block; software streams message words in and reads the final CRC on out_valid.

Parameters:
- CRC_W, 32: CRC width in bits; legal range 8..32.
- POLY, 32'h04C11DB7: generator polynomial, implicit top bit; only the low CRC_W bits are used.
- INIT, 32'hFFFFFFFF: register value at reset, at crc_clear, and after each message completes; low CRC_W bits used.
- XOR_OUT, 32'h00000000: value XORed onto the final result; low CRC_W bits used.
- DATA_W, 32: input word width.
- BPC, 1: bits folded per clock; must divide DATA_W, 1 <= BPC <= DATA_W.
- REFLECT_IN, 0: 1 = word bits consumed LSB-first; 0 = MSB-first.
- REFLECT_OUT, 0: 1 = bit-reverse the CRC register before XOR_OUT.

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous reset, active-low.
- crc_clear  in  1  synchronous reinitialise; aborts any operation in progress.
- in_valid  in  1  in_data / in_last valid.
- in_ready  out  1  engine can accept a word.
- in_data  in  DATA_W  message word.
- in_last  in  1  this word ends the message.
- busy  out  1  high while a word is being folded.
- out_valid  out  1  one-cycle pulse: crc_out holds a new result.
- crc_out  out  CRC_W  final CRC of the most recent completed message.

Behaviour:
- Reset (nRST low), asynchronous:
  - state=IDLE, crc register=INIT, step counter=0
  - out_valid=0, crc_out=0, busy=0
  - in_ready=1 once nRST is released.
- States: IDLE, SHIFT.
- IDLE:
  - in_ready = !crc_clear.
  - On in_valid && in_ready at edge k: capture in_data into the shift register, in_last into last_q, counter=0, go to SHIFT.
- SHIFT:
  - in_ready=0, busy=1.
  - Each edge folds BPC bits, sequentially within the cycle, MSB-first (or LSB-first if REFLECT_IN).
  - Per bit b: fb = crc[CRC_W-1] ^ b; crc = (crc << 1) ^ (fb ? POLY : 0), truncated to CRC_W bits.
  - N = DATA_W/BPC steps occur at edges k+1..k+N. At edge k+N the state returns to IDLE, and in_ready is high in the following cycle.
  - Back-to-back word throughput: one word per N+1 cycles.
- Completion, at edge k+N with last_q=1:
  - crc_out = (REFLECT_OUT ? bitrev(crc_final) : crc_final) ^ XOR_OUT.
  - out_valid=1 for exactly that one cycle.
  - crc register reloads INIT.
- Completion with last_q=0: the crc register retains the running value; out_valid stays 0.
- crc_out holds its value until the next completion; crc_clear does not alter crc_out.
- crc_clear (highest priority, any state): next edge state=IDLE, crc=INIT, counter=0, no out_valid, the word in flight is discarded, and no word is accepted in that cycle.
- Simultaneous crc_clear and in_valid in IDLE: the clear wins and the word is not accepted (in_ready=0).
- in_valid while in_ready=0: ignored. The source holds in_data / in_last stable until handshake completes.
- Counter width: clog2(N)+1; it wraps to 0 on return to IDLE.
- BPC=DATA_W: the fold is fully combinational and N=1, so 2 cycles per word.
- Illegal parameters (BPC not dividing DATA_W, CRC_W out of range): elaboration-time assertion fails.

Test Plan:
1. CRC-32/MPEG-2 check value. Config: DATA_W=8, BPC=1, defaults. Stimulus: ASCII "123456789", one byte per handshake, in_last on '9'. Required: crc_out=0x0376E6E7 with a single out_valid pulse, 8 cycles after the last acceptance edge.
2. CRC-32 (ISO-HDLC) check value. Config: DATA_W=8, BPC=8, REFLECT_IN=1, REFLECT_OUT=1, XOR_OUT=32'hFFFFFFFF. Stimulus: same bytes. Required: crc_out=0xCBF43926, with a 2-cycle word period observed on in_ready.
3. Width and polynomial parameters. Config: CRC_W=16, POLY=16'h1021, INIT=16'hFFFF, DATA_W=8, BPC=4. Stimulus: "123456789". Required: crc_out=0x29B1.
4. Multi-word running CRC. Config: DATA_W=32, BPC=1, defaults. Stimulus: words 0x31323334, 0x35363738, then a second message. Required: in_ready low for exactly 32 cycles per word; out_valid only after the in_last word; the second message's CRC is independent of the first, because INIT reloads after completion.
5. crc_clear mid-SHIFT. Stimulus: assert crc_clear at step 10 of 32 of a last word. Required: no out_valid; in_ready=1 next cycle; crc_out unchanged; a subsequent "123456789" run gives the test-1 result.
6. Async reset mid-SHIFT. Stimulus: drop nRST at step 5, then release. Required: busy=0, out_valid=0 and crc_out=0 immediately; in_ready=1 after release; next message correct.
